// File: rtl/adder_tree_sched.sv
// adder_tree_sched: round-robin scheduler of SA groups onto the adder tree; ports: clk, reset (async, active-low), enable, cfg_we/cfg_addr/cfg_mask (group table write), sa_ready in; control, sa_ack, result_valid, result_grp, busy out (all registered)
module adder_tree_sched #(
  parameter int NUM_SA   = 8,
  parameter int NUM_GRP  = 4,
  parameter int GRP_W    = 2,
  parameter int SER_CYC  = 8,
  parameter int TREE_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_we,
  input  logic [GRP_W-1:0]  cfg_addr,
  input  logic [NUM_SA-1:0] cfg_mask,
  input  logic [NUM_SA-1:0] sa_ready,
  output logic [NUM_SA-1:0] control,
  output logic [NUM_SA-1:0] sa_ack,
  output logic              result_valid,
  output logic [GRP_W-1:0]  result_grp,
  output logic              busy
);
  localparam int CW = $clog2((SER_CYC > TREE_LAT ? SER_CYC : TREE_LAT) + 1);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [NUM_SA-1:0] tbl [NUM_GRP];
  logic [NUM_SA-1:0] act_mask, act_mask_n;
  logic [GRP_W-1:0]  act_grp, act_grp_n, rr_ptr, rr_ptr_n, pick, idx;
  logic [CW-1:0]     cnt, cnt_n;
  logic              found;
  // descending scan so the lowest offset from rr_ptr wins
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    idx   = '0;
    for (int i = NUM_GRP - 1; i >= 0; i--) begin
      idx = rr_ptr + GRP_W'(i);
      if (tbl[idx] != '0 && (tbl[idx] & ~sa_ready) == '0) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    act_mask_n = act_mask;
    act_grp_n  = act_grp;
    rr_ptr_n   = rr_ptr;
    case (state)
      IDLE: if (enable && found) begin
        state_n    = FEED;
        cnt_n      = CW'(SER_CYC - 1);
        act_mask_n = tbl[pick];
        act_grp_n  = pick;
        rr_ptr_n   = pick + GRP_W'(1);
      end
      FEED: begin
        state_n = cnt == '0 ? DRAIN : FEED;
        cnt_n   = cnt == '0 ? CW'(TREE_LAT - 1) : cnt - CW'(1);
      end
      DRAIN: begin
        state_n = cnt == '0 ? DONE : DRAIN;
        cnt_n   = cnt == '0 ? '0 : cnt - CW'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      act_mask     <= '0;
      act_grp      <= '0;
      rr_ptr       <= '0;
      control      <= '0;
      sa_ack       <= '0;
      result_valid <= 1'b0;
      result_grp   <= '0;
      busy         <= 1'b0;
      for (int i = 0; i < NUM_GRP; i++) tbl[i] <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      act_mask     <= act_mask_n;
      act_grp      <= act_grp_n;
      rr_ptr       <= rr_ptr_n;
      control      <= state_n == FEED ? act_mask_n : '0;
      sa_ack       <= state_n == DONE ? act_mask_n : '0;
      result_valid <= state_n == DONE;
      result_grp   <= state_n == DONE ? act_grp_n : result_grp;
      busy         <= state_n != IDLE;
      if (cfg_we) tbl[cfg_addr] <= cfg_mask;
    end
  end
endmodule
